// File: rtl/fetch_pair_buffer_pkg.sv
// rtl/fetch_pair_buffer_pkg.sv - shared fetch/decode constants, IF/ID field widths and pairing states
package fetch_pair_buffer_pkg;

   localparam int INSTR_W         = 16;
   localparam int IMM_W           = 16;
   localparam int PC_W_DEFAULT    = 32;
   localparam int IMM_BIT_DEFAULT = 2;

   localparam logic [INSTR_W-1:0] NOP_WORD_DEFAULT = 16'h0000;

   typedef enum logic {
      S_INSTR = 1'b0,
      S_IMM   = 1'b1
   } pair_state_t;

endpackage

// File: rtl/fetch_pair_buffer_if_id_reg.sv
// rtl/fetch_pair_buffer_if_id_reg.sv - IF/ID bundle register with load, hold and bubble controls
module fetch_pair_buffer_if_id_reg
   import fetch_pair_buffer_pkg::*;
#(
   parameter int                 PC_W     = PC_W_DEFAULT,
   parameter logic [INSTR_W-1:0] NOP_WORD = NOP_WORD_DEFAULT
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load,
   input  logic               bubble,
   input  logic [INSTR_W-1:0] d_instruction,
   input  logic [IMM_W-1:0]   d_immediate,
   input  logic [PC_W-1:0]    d_pc,
   input  logic               d_has_imm,
   output logic [INSTR_W-1:0] id_instruction,
   output logic [IMM_W-1:0]   id_immediate,
   output logic [PC_W-1:0]    id_pc,
   output logic               id_has_imm,
   output logic               id_valid
);

   // Bubble wins over load; neither asserted means hold. The pc is left as-is
   // on a bubble since decode ignores it while id_valid is low.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         id_instruction <= NOP_WORD;
         id_immediate   <= '0;
         id_pc          <= '0;
         id_has_imm     <= 1'b0;
         id_valid       <= 1'b0;
      end else if (bubble) begin
         id_instruction <= NOP_WORD;
         id_immediate   <= '0;
         id_has_imm     <= 1'b0;
         id_valid       <= 1'b0;
      end else if (load) begin
         id_instruction <= d_instruction;
         id_immediate   <= d_immediate;
         id_pc          <= d_pc;
         id_has_imm     <= d_has_imm;
         id_valid       <= 1'b1;
      end
   end

endmodule

// File: rtl/fetch_pair_buffer.sv
// rtl/fetch_pair_buffer.sv - IF/ID buffer pairing flagged instruction words with their immediate
module fetch_pair_buffer
   import fetch_pair_buffer_pkg::*;
#(
   parameter int                 PC_W     = PC_W_DEFAULT,
   parameter int                 IMM_BIT  = IMM_BIT_DEFAULT,
   parameter logic [INSTR_W-1:0] NOP_WORD = NOP_WORD_DEFAULT
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [INSTR_W-1:0] fetch_word,
   input  logic [PC_W-1:0]    fetch_pc,
   input  logic               fetch_valid,
   output logic               fetch_ready,
   input  logic               stall,
   input  logic               flush,
   output logic [INSTR_W-1:0] id_instruction,
   output logic [IMM_W-1:0]   id_immediate,
   output logic [PC_W-1:0]    id_pc,
   output logic               id_has_imm,
   output logic               id_valid
);

   pair_state_t        state;
   logic [INSTR_W-1:0] pend_instr;
   logic [PC_W-1:0]    pend_pc;

   logic               accept;
   logic               imm_flag;
   logic               start_pair;
   logic               load;
   logic               bubble;
   logic [INSTR_W-1:0] d_instruction;
   logic [IMM_W-1:0]   d_immediate;
   logic [PC_W-1:0]    d_pc;
   logic               d_has_imm;

   assign fetch_ready = !stall || flush;
   assign accept      = fetch_valid && !stall && !flush;
   assign imm_flag    = fetch_word[IMM_BIT];

   // The flag is only meaningful on an instruction word; in S_IMM the word is data.
   assign start_pair  = accept && (state == S_INSTR) && imm_flag;

   always_comb begin
      load          = accept && !start_pair;
      bubble        = flush || (!stall && !accept) || start_pair;
      d_instruction = fetch_word;
      d_immediate   = '0;
      d_pc          = fetch_pc;
      d_has_imm     = 1'b0;
      if (state == S_IMM) begin
         d_instruction = pend_instr;
         d_immediate   = fetch_word;
         d_pc          = pend_pc;
         d_has_imm     = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_INSTR;
         pend_instr <= '0;
         pend_pc    <= '0;
      end else if (flush) begin
         state      <= S_INSTR;
         pend_instr <= '0;
         pend_pc    <= '0;
      end else if (accept) begin
         case (state)
            S_INSTR: begin
               if (imm_flag) begin
                  state      <= S_IMM;
                  pend_instr <= fetch_word;
                  pend_pc    <= fetch_pc;
               end
            end
            S_IMM: begin
               state <= S_INSTR;
            end
            default: begin
               state <= S_INSTR;
            end
         endcase
      end
   end

   fetch_pair_buffer_if_id_reg #(
      .PC_W     (PC_W),
      .NOP_WORD (NOP_WORD)
   ) u_if_id_reg (
      .clk            (clk),
      .rst_n          (rst_n),
      .load           (load),
      .bubble         (bubble),
      .d_instruction  (d_instruction),
      .d_immediate    (d_immediate),
      .d_pc           (d_pc),
      .d_has_imm      (d_has_imm),
      .id_instruction (id_instruction),
      .id_immediate   (id_immediate),
      .id_pc          (id_pc),
      .id_has_imm     (id_has_imm),
      .id_valid       (id_valid)
   );

endmodule

// File: tb/tb_fetch_pair_buffer.sv
// tb/tb_fetch_pair_buffer.sv - scoreboard bench for fetch_pair_buffer with directed fetch streams
module tb_fetch_pair_buffer;

   localparam int PC_W = 32;

   logic            clk = 1'b0;
   logic            rst_n = 1'b1;
   logic [15:0]     fetch_word = '0;
   logic [PC_W-1:0] fetch_pc = '0;
   logic            fetch_valid = 1'b0;
   logic            fetch_ready;
   logic            stall = 1'b0;
   logic            flush = 1'b0;
   logic [15:0]     id_instruction;
   logic [15:0]     id_immediate;
   logic [PC_W-1:0] id_pc;
   logic            id_has_imm;
   logic            id_valid;

   typedef struct packed {
      logic [15:0]     instr;
      logic [15:0]     imm;
      logic [PC_W-1:0] pc;
      logic            has_imm;
   } bundle_t;

   bundle_t exp_q[$];
   int      vectors = 0;
   int      miscompares = 0;
   logic    last_hold = 1'b0;

   fetch_pair_buffer #(
      .PC_W     (PC_W),
      .IMM_BIT  (2),
      .NOP_WORD (16'h0000)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .fetch_word     (fetch_word),
      .fetch_pc       (fetch_pc),
      .fetch_valid    (fetch_valid),
      .fetch_ready    (fetch_ready),
      .stall          (stall),
      .flush          (flush),
      .id_instruction (id_instruction),
      .id_immediate   (id_immediate),
      .id_pc          (id_pc),
      .id_has_imm     (id_has_imm),
      .id_valid       (id_valid)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic push(input logic [15:0] instr, input logic [15:0] imm,
                       input logic [PC_W-1:0] pc, input logic has_imm);
      bundle_t b;
      b.instr   = instr;
      b.imm     = imm;
      b.pc      = pc;
      b.has_imm = has_imm;
      exp_q.push_back(b);
   endtask

   task automatic issue(input logic [15:0] w, input logic [PC_W-1:0] pc, input logic v);
      fetch_word  = w;
      fetch_pc    = pc;
      fetch_valid = v;
      @(posedge clk);
      #1;
      fetch_valid = 1'b0;
   endtask

   // Monitor: on each negedge, a fresh valid bundle is popped and compared;
   // a fresh non-valid output must be a clean bubble. Held cycles are skipped.
   always @(negedge clk) begin
      bundle_t b;
      if (!last_hold) begin
         if (id_valid) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_bundle", {16'h0, id_instruction}, 32'hFFFF_FFFF);
            end else begin
               b = exp_q.pop_front();
               chk("instruction", {16'h0, id_instruction}, {16'h0, b.instr});
               chk("immediate", {16'h0, id_immediate}, {16'h0, b.imm});
               chk("pc", id_pc, b.pc);
               chk("has_imm", {31'h0, id_has_imm}, {31'h0, b.has_imm});
            end
         end else begin
            chk("bubble_instr", {16'h0, id_instruction}, 32'h0);
            chk("bubble_imm", {16'h0, id_immediate}, 32'h0);
            chk("bubble_has_imm", {31'h0, id_has_imm}, 32'h0);
         end
      end
      last_hold = stall && !flush && rst_n;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      #2 rst_n = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      chk("rst_valid", {31'h0, id_valid}, 32'h0);
      chk("rst_instr", {16'h0, id_instruction}, 32'h0);
      chk("rst_imm", {16'h0, id_immediate}, 32'h0);
      chk("rst_pc", id_pc, 32'h0);
      chk("rst_has_imm", {31'h0, id_has_imm}, 32'h0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // single word instruction
      push(16'h1230, 16'h0000, 32'h10, 1'b0);
      issue(16'h1230, 32'h10, 1'b1);

      // back-to-back pair
      push(16'h0004, 16'hBEEF, 32'h20, 1'b1);
      issue(16'h0004, 32'h20, 1'b1);
      chk("pair_first_edge_valid", {31'h0, id_valid}, 32'h0);
      issue(16'hBEEF, 32'h21, 1'b1);

      // pair with a gap; immediate has bit2 set but is pure data
      push(16'h0004, 16'h00FF, 32'h30, 1'b1);
      issue(16'h0004, 32'h30, 1'b1);
      for (int i = 0; i < 3; i++) issue(16'h0000, 32'h0, 1'b0);
      issue(16'h00FF, 32'h31, 1'b1);
      issue(16'h0000, 32'h0, 1'b0);

      // stall holds a valid bundle
      push(16'h1230, 16'h0000, 32'h40, 1'b0);
      issue(16'h1230, 32'h40, 1'b1);
      stall       = 1'b1;
      fetch_word  = 16'h5555;
      fetch_pc    = 32'h41;
      fetch_valid = 1'b1;
      #1;
      chk("stall_ready", {31'h0, fetch_ready}, 32'h0);
      for (int i = 0; i < 2; i++) begin
         @(posedge clk);
         #1;
         chk("stall_valid", {31'h0, id_valid}, 32'h1);
         chk("stall_instr", {16'h0, id_instruction}, 32'h1230);
         chk("stall_pc", id_pc, 32'h40);
      end
      stall = 1'b0;
      push(16'h0008, 16'h0000, 32'h44, 1'b0);
      issue(16'h0008, 32'h44, 1'b1);

      // flush in S_IMM dominates stall and fetch_valid
      issue(16'h0004, 32'h50, 1'b1);
      stall       = 1'b1;
      flush       = 1'b1;
      fetch_word  = 16'h1111;
      fetch_pc    = 32'h51;
      fetch_valid = 1'b1;
      #1;
      chk("flush_ready", {31'h0, fetch_ready}, 32'h1);
      @(posedge clk);
      #1;
      stall       = 1'b0;
      flush       = 1'b0;
      fetch_valid = 1'b0;
      chk("flush_valid", {31'h0, id_valid}, 32'h0);
      chk("flush_instr", {16'h0, id_instruction}, 32'h0);
      push(16'h1230, 16'h0000, 32'h52, 1'b0);
      issue(16'h1230, 32'h52, 1'b1);

      // async reset while waiting for an immediate
      issue(16'h0004, 32'h60, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_valid", {31'h0, id_valid}, 32'h0);
      chk("arst_pc", id_pc, 32'h0);
      chk("arst_instr", {16'h0, id_instruction}, 32'h0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      push(16'h0008, 16'h0000, 32'h64, 1'b0);
      issue(16'h0008, 32'h64, 1'b1);

      for (int i = 0; i < 4; i++) issue(16'h0000, 32'h0, 1'b0);
      chk("scoreboard_empty", exp_q.size(), 32'h0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
